// File: rtl/stress_pkg.sv
// Package stress_pkg
//   Shared defaults and width helpers for the multi-channel stress detector.
//   Default channel count, sample width, averaging window and tick limits live
//   here so the top, the channel slice and the bench agree on one set of numbers.
//   Optional feature macro used by importing files: STRESS_TIMEOUT_EN.
package stress_pkg;

    localparam int N_CH_DEF          = 2;
    localparam int DATA_W_DEF        = 8;
    localparam int AVG_LOG2_DEF      = 2;
    localparam int HOLD_TICKS_DEF    = 12;
    localparam int TIMEOUT_TICKS_DEF = 8;

    // Running sum of 2**avg_log2 samples of data_w bits never overflows this width.
    function automatic int sum_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int SUM_W_DEF  = sum_width(DATA_W_DEF, AVG_LOG2_DEF);
    localparam int HOLD_W_DEF = cnt_width(HOLD_TICKS_DEF);
    localparam int TO_W_DEF   = cnt_width(TIMEOUT_TICKS_DEF);

endpackage

// File: rtl/stress_chan.sv
// Module stress_chan
//   One sensor channel: circular sample buffer, running sum, registered
//   moving average and a set/clear hysteresis flag. With STRESS_TIMEOUT_EN
//   defined it also counts ticks since the last sample and flags a fault.
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   tick          slow strobe (present only with STRESS_TIMEOUT_EN)
//   sample_data   new sample, taken when sample_valid is high
//   sample_valid  one-cycle sample strobe
//   thr_hi        set threshold (avg > thr_hi sets stressed)
//   thr_lo        clear threshold (avg < thr_lo clears stressed)
//   avg           registered moving average
//   stressed      hysteresis state, forced low while faulted
//   fault         sample timeout flag (constant 0 without STRESS_TIMEOUT_EN)
// Handshake: sample_valid is a plain strobe with no ready/back-pressure; every
// cycle with sample_valid high consumes exactly one sample.
module stress_chan
    import stress_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int AVG_LOG2      = AVG_LOG2_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic              clk,
    input  logic              reset,
`ifdef STRESS_TIMEOUT_EN
    input  logic              tick,
`endif
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic [DATA_W-1:0] avg,
    output logic              stressed,
    output logic              fault
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = sum_width(DATA_W, AVG_LOG2);

    logic [DATA_W-1:0]   buf_q [DEPTH];
    logic [AVG_LOG2-1:0] wp_q;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_nxt;
    logic [DATA_W-1:0]   avg_q;
    logic                stressed_q;

    // Drop the oldest sample (the slot about to be overwritten) and add the new one.
    always_comb begin
        sum_nxt = sum_q - SUM_W'(buf_q[wp_q]) + SUM_W'(sample_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                buf_q[k] <= '0;
            end
            wp_q  <= '0;
            sum_q <= '0;
            avg_q <= '0;
        end else if (sample_valid) begin
            buf_q[wp_q] <= sample_data;
            wp_q        <= wp_q + 1'b1;
            sum_q       <= sum_nxt;
            avg_q       <= DATA_W'(sum_nxt >> AVG_LOG2);
        end
    end

`ifdef STRESS_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT_TICKS);

    logic [TO_W-1:0] to_cnt_q;

    // A sample in the same cycle as a tick restarts the count.
    always_ff @(posedge clk) begin
        if (reset || sample_valid) begin
            to_cnt_q <= '0;
        end else if (tick && (to_cnt_q != TO_W'(TIMEOUT_TICKS))) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign fault = (to_cnt_q == TO_W'(TIMEOUT_TICKS));
`else
    assign fault = 1'b0;
`endif

    // Hysteresis on the registered average; set has priority when the
    // thresholds overlap. A faulted channel restarts from the clear state.
    always_ff @(posedge clk) begin
        if (reset || fault) begin
            stressed_q <= 1'b0;
        end else if (avg_q > thr_hi) begin
            stressed_q <= 1'b1;
        end else if (avg_q < thr_lo) begin
            stressed_q <= 1'b0;
        end
    end

    assign avg      = avg_q;
    assign stressed = stressed_q & ~fault;

endmodule

// File: rtl/stress_multi.sv
// Module stress_multi
//   N_CH-channel stress detector. Each channel keeps a moving average and a
//   hysteresis flag (stress_chan); this level combines the flags and runs the
//   hold counter that drives stress_continu on the slow tick.
//   Optional feature macro: STRESS_TIMEOUT_EN (per-channel sample timeout).
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   tick            one-cycle slow strobe advancing the hold counter
//   sample_data     packed samples, channel i at [i*DATA_W +: DATA_W]
//   sample_valid    per-channel one-cycle sample strobe, no back-pressure
//   thr_hi, thr_lo  packed per-channel set / clear thresholds
//   avg_out         packed registered per-channel averages
//   ch_stressed     per-channel hysteresis state
//   stress_low      1 when no channel is stressed
//   stress_continu  1 once some channel has been stressed for HOLD_TICKS ticks
//   sensor_fault    per-channel sample timeout (0 without STRESS_TIMEOUT_EN)
module stress_multi
    import stress_pkg::*;
#(
    parameter int N_CH          = N_CH_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int AVG_LOG2      = AVG_LOG2_DEF,
    parameter int HOLD_TICKS    = HOLD_TICKS_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [N_CH*DATA_W-1:0] sample_data,
    input  logic [N_CH-1:0]        sample_valid,
    input  logic [N_CH*DATA_W-1:0] thr_hi,
    input  logic [N_CH*DATA_W-1:0] thr_lo,
    output logic [N_CH*DATA_W-1:0] avg_out,
    output logic [N_CH-1:0]        ch_stressed,
    output logic                   stress_low,
    output logic                   stress_continu,
    output logic [N_CH-1:0]        sensor_fault
);

    localparam int HOLD_W = cnt_width(HOLD_TICKS);

    logic [HOLD_W-1:0] hold_cnt_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        stress_chan #(
            .DATA_W        (DATA_W),
            .AVG_LOG2      (AVG_LOG2),
            .TIMEOUT_TICKS (TIMEOUT_TICKS)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
`ifdef STRESS_TIMEOUT_EN
            .tick         (tick),
`endif
            .sample_data  (sample_data[i*DATA_W +: DATA_W]),
            .sample_valid (sample_valid[i]),
            .thr_hi       (thr_hi[i*DATA_W +: DATA_W]),
            .thr_lo       (thr_lo[i*DATA_W +: DATA_W]),
            .avg          (avg_out[i*DATA_W +: DATA_W]),
            .stressed     (ch_stressed[i]),
            .fault        (sensor_fault[i])
        );
    end

    // Counts consecutive ticks with any channel stressed, saturating at
    // HOLD_TICKS; one unstressed tick restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else if (tick) begin
            if (|ch_stressed) begin
                if (hold_cnt_q != HOLD_W'(HOLD_TICKS)) begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end
            end else begin
                hold_cnt_q <= '0;
            end
        end
    end

    assign stress_low     = ~|ch_stressed;
    assign stress_continu = (hold_cnt_q == HOLD_W'(HOLD_TICKS));

endmodule

// File: tb/tb_stress_multi.sv
// Testbench tb_stress_multi
//   Directed, table-driven bench for stress_multi with default parameters
//   (2 channels, 8-bit data, window of 4, hold 12 ticks, timeout 8 ticks).
//   Sequences for the timeout fault run only when STRESS_TIMEOUT_EN is defined.
module tb_stress_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [15:0] sample_data;
    logic [1:0]  sample_valid;
    logic [15:0] thr_hi;
    logic [15:0] thr_lo;
    logic [15:0] avg_out;
    logic [1:0]  ch_stressed;
    logic        stress_low;
    logic        stress_continu;
    logic [1:0]  sensor_fault;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] e_avg0;
        logic [7:0] e_avg1;
        logic [1:0] e_st;
    } vec_t;

    vec_t tbl [13];

    stress_multi dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .thr_hi         (thr_hi),
        .thr_lo         (thr_lo),
        .avg_out        (avg_out),
        .ch_stressed    (ch_stressed),
        .stress_low     (stress_low),
        .stress_continu (stress_continu),
        .sensor_fault   (sensor_fault)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver: hold inputs for one active edge, sample 1 time unit after it.
    task automatic pulse(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic t);
        sample_valid = v;
        sample_data  = {d1, d0};
        tick         = t;
        @(posedge clk);
        #1;
        sample_valid = 2'b00;
        tick         = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        reset        = 1'b0;
        tick         = 1'b0;
        sample_valid = 2'b00;
        sample_data  = '0;
        // ch0: set above 100, clear below 50; ch1: thresholds unreachable
        thr_hi = {8'd255, 8'd100};
        thr_lo = {8'd0,   8'd50};

        // Running-average table for ch0; stressed lags the average by one cycle
        tbl[0]  = '{2'b01, 8'd200, 8'd0, 8'd50,  8'd0, 2'b00};
        tbl[1]  = '{2'b01, 8'd200, 8'd0, 8'd100, 8'd0, 2'b00};
        tbl[2]  = '{2'b01, 8'd200, 8'd0, 8'd150, 8'd0, 2'b00};
        tbl[3]  = '{2'b01, 8'd200, 8'd0, 8'd200, 8'd0, 2'b01};
        tbl[4]  = '{2'b01, 8'd80,  8'd0, 8'd170, 8'd0, 2'b01};
        tbl[5]  = '{2'b01, 8'd80,  8'd0, 8'd140, 8'd0, 2'b01};
        tbl[6]  = '{2'b01, 8'd80,  8'd0, 8'd110, 8'd0, 2'b01};
        tbl[7]  = '{2'b01, 8'd80,  8'd0, 8'd80,  8'd0, 2'b01};
        tbl[8]  = '{2'b01, 8'd30,  8'd0, 8'd67,  8'd0, 2'b01};
        tbl[9]  = '{2'b01, 8'd30,  8'd0, 8'd55,  8'd0, 2'b01};
        tbl[10] = '{2'b01, 8'd30,  8'd0, 8'd42,  8'd0, 2'b01};
        tbl[11] = '{2'b01, 8'd30,  8'd0, 8'd30,  8'd0, 2'b00};
        tbl[12] = '{2'b00, 8'd0,   8'd0, 8'd30,  8'd0, 2'b00};

        // 1: reset state
        do_reset(2);
        chk("rst_avg", 32'(avg_out), 32'd0);
        chk("rst_stressed", 32'(ch_stressed), 32'd0);
        chk("rst_low", 32'(stress_low), 32'd1);
        chk("rst_continu", 32'(stress_continu), 32'd0);
        chk("rst_fault", 32'(sensor_fault), 32'd0);

        // 2/3: moving average and hysteresis
        for (int i = 0; i < 13; i++) begin
            pulse(tbl[i].valid, tbl[i].d0, tbl[i].d1, 1'b0);
            chk($sformatf("tbl%0d_avg", i), 32'(avg_out), 32'({tbl[i].e_avg1, tbl[i].e_avg0}));
            chk($sformatf("tbl%0d_st", i), 32'(ch_stressed), 32'(tbl[i].e_st));
            chk($sformatf("tbl%0d_low", i), 32'(stress_low), 32'(~|tbl[i].e_st));
        end

        // 4: hold counter. Re-stress ch0 (buffer holds 30s): avg 72,115,157,200
        for (int i = 0; i < 4; i++) pulse(2'b01, 8'd200, 8'd0, 1'b0);
        pulse(2'b00, 8'd0, 8'd0, 1'b0);
        chk("hold_pre_avg0", 32'(avg_out[7:0]), 32'd200);
        chk("hold_pre_st", 32'(ch_stressed), 32'd1);
        chk("hold_pre_continu", 32'(stress_continu), 32'd0);
        // Keep both channels fed so neither can time out
        for (int i = 1; i <= 13; i++) begin
            pulse(2'b11, 8'd200, 8'd0, 1'b1);
            if (i == 11) chk("hold_tick11", 32'(stress_continu), 32'd0);
            if (i == 12) chk("hold_tick12", 32'(stress_continu), 32'd1);
            if (i == 13) chk("hold_tick13_sat", 32'(stress_continu), 32'd1);
        end
        chk("hold_fault", 32'(sensor_fault), 32'd0);
        chk("hold_low", 32'(stress_low), 32'd0);
        // Drain ch0 to 0: avg 150,100,50,0; flag clears one cycle after avg=0
        for (int i = 0; i < 4; i++) pulse(2'b01, 8'd0, 8'd0, 1'b0);
        pulse(2'b00, 8'd0, 8'd0, 1'b0);
        chk("drain_st", 32'(ch_stressed), 32'd0);
        chk("drain_continu_held", 32'(stress_continu), 32'd1);
        pulse(2'b00, 8'd0, 8'd0, 1'b1);
        chk("drain_continu_fall", 32'(stress_continu), 32'd0);
        chk("drain_low", 32'(stress_low), 32'd1);

        // 5: simultaneous valids and tick; ch0/ch1 buffers are all zero
        pulse(2'b11, 8'd40, 8'd100, 1'b1);
        chk("simul_avg", 32'(avg_out), 32'({8'd25, 8'd10}));
        chk("simul_continu", 32'(stress_continu), 32'd0);
        pulse(2'b01, 8'd200, 8'd0, 1'b0);
        pulse(2'b01, 8'd200, 8'd0, 1'b0);
        chk("mid_avg0", 32'(avg_out[7:0]), 32'd110);
        do_reset(1);
        chk("mid_rst_avg", 32'(avg_out), 32'd0);
        chk("mid_rst_fault", 32'(sensor_fault), 32'd0);
        pulse(2'b01, 8'd200, 8'd0, 1'b0);
        chk("post_rst_avg", 32'(avg_out), 32'({8'd0, 8'd50}));

`ifdef STRESS_TIMEOUT_EN
        // 6: ch1 goes silent while stressed; ch0 keeps sampling
        thr_hi = {8'd10, 8'd100};
        thr_lo = {8'd5,  8'd50};
        pulse(2'b10, 8'd0, 8'd200, 1'b0);
        pulse(2'b00, 8'd0, 8'd0, 1'b0);
        chk("to_pre_st", 32'(ch_stressed), 32'd2);
        for (int i = 1; i <= 8; i++) begin
            pulse(2'b01, 8'd0, 8'd0, 1'b1);
            if (i == 7) begin
                chk("to_tick7_fault", 32'(sensor_fault), 32'd0);
                chk("to_tick7_st", 32'(ch_stressed), 32'd2);
            end
        end
        chk("to_fault", 32'(sensor_fault), 32'd2);
        chk("to_st", 32'(ch_stressed), 32'd0);
        chk("to_low", 32'(stress_low), 32'd1);
        pulse(2'b10, 8'd0, 8'd200, 1'b0);
        chk("to_clear_fault", 32'(sensor_fault), 32'd0);
        chk("to_history_avg1", 32'(avg_out[15:8]), 32'd100);
        pulse(2'b00, 8'd0, 8'd0, 1'b0);
        chk("to_restress", 32'(ch_stressed), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
